// File: rtl/data_stack_unit_pkg.sv
// Shared definitions for the data stack unit.
//   - Default stack word width and backing-RAM address width.
//   - Opcode and controller state encodings.
//   - stack_cap(): total entries held = RAM words plus the two register slots.
package data_stack_unit_pkg;

   localparam int STACK_WIDTH     = 16;
   localparam int DATA_STACK_SIZE = 8;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_PUSH  = 2'd1,
      OP_POP   = 2'd2,
      OP_BINOP = 2'd3
   } op_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   // Capacity: every RAM word plus TOS and NOS.
   function automatic int stack_cap(input int addr_w);
      return (32'sd1 <<< addr_w) + 32'sd2;
   endfunction

endpackage

// File: rtl/data_stack_unit_if.sv
// Core-side stack port.
//   master (core): drives op_valid, op, push_data; sees op_ready, tos, nos,
//                  depth, overflow, underflow.
//   slave  (unit): the mirror image.
interface data_stack_unit_if
   import data_stack_unit_pkg::*;
#(
   parameter int WIDTH  = STACK_WIDTH,
   parameter int ADDR_W = DATA_STACK_SIZE
);
   logic              op_valid;
   op_t               op;
   logic [WIDTH-1:0]  push_data;
   logic              op_ready;
   logic [WIDTH-1:0]  tos;
   logic [WIDTH-1:0]  nos;
   logic [ADDR_W+1:0] depth;
   logic              overflow;
   logic              underflow;

   modport master (
      output op_valid, op, push_data,
      input  op_ready, tos, nos, depth, overflow, underflow
   );

   modport slave (
      input  op_valid, op, push_data,
      output op_ready, tos, nos, depth, overflow, underflow
   );
endinterface

// File: rtl/data_stack_unit.sv
// Hardware data stack: TOS/NOS in registers, deeper entries in an external
// synchronous single-port RAM (registered read, one cycle latency).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   core       data_stack_unit_if.slave: op handshake, tos/nos/depth, sticky flags
//   ram_addr   RAM address (equals sp when idle)
//   ram_wdata  RAM write data (spilled NOS)
//   ram_wen    RAM write enable, only on an accepted spilling PUSH
//   ram_rdata  RAM read data, consumed in the REFILL cycle
module data_stack_unit
   import data_stack_unit_pkg::*;
#(
   parameter int WIDTH  = STACK_WIDTH,
   parameter int ADDR_W = DATA_STACK_SIZE
) (
   input  logic              clk,
   input  logic              reset,
   data_stack_unit_if.slave  core,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [WIDTH-1:0]  ram_wdata,
   output logic              ram_wen,
   input  logic [WIDTH-1:0]  ram_rdata
);

   localparam int DW = ADDR_W + 2;
   localparam int SW = ADDR_W + 1;
   localparam logic [DW-1:0] CAP_D = DW'(stack_cap(ADDR_W));

   state_t           state_r;
   logic [WIDTH-1:0] tos_r;
   logic [WIDTH-1:0] nos_r;
   logic [DW-1:0]    depth_r;
   logic [SW-1:0]    sp_r;      // entries currently held in RAM
   logic             overflow_r;
   logic             underflow_r;

   logic             fire_s;
   logic [SW-1:0]    sp_dec_s;

   assign fire_s   = core.op_valid && (state_r == ST_IDLE);
   assign sp_dec_s = sp_r - SW'(1);

   assign core.op_ready  = (state_r == ST_IDLE);
   assign core.tos       = tos_r;
   assign core.nos       = nos_r;
   assign core.depth     = depth_r;
   assign core.overflow  = overflow_r;
   assign core.underflow = underflow_r;

   // RAM port: spill old NOS on a push past two entries, address sp-1 on a refilling pop/binop.
   always_comb begin
      ram_wen   = 1'b0;
      ram_addr  = sp_r[ADDR_W-1:0];
      ram_wdata = nos_r;
      if (fire_s) begin
         case (core.op)
            OP_PUSH: begin
               if ((depth_r >= DW'(2)) && (depth_r < CAP_D)) begin
                  ram_wen = 1'b1;
               end else begin
                  ram_wen = 1'b0;
               end
            end
            OP_POP, OP_BINOP: begin
               if (depth_r >= DW'(3)) begin
                  ram_addr = sp_dec_s[ADDR_W-1:0];
               end else begin
                  ram_addr = sp_r[ADDR_W-1:0];
               end
            end
            default: begin
               ram_wen = 1'b0;
            end
         endcase
      end else begin
         ram_wen = 1'b0;
      end
   end

   // Stack controller: register slots, sp, sticky flags and the one-cycle refill state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         tos_r       <= '0;
         nos_r       <= '0;
         depth_r     <= '0;
         sp_r        <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (fire_s) begin
                  case (core.op)
                     OP_PUSH: begin
                        if (depth_r == CAP_D) begin
                           overflow_r <= 1'b1;
                        end else begin
                           nos_r   <= tos_r;
                           tos_r   <= core.push_data;
                           depth_r <= depth_r + DW'(1);
                           if (depth_r >= DW'(2)) begin
                              sp_r <= sp_r + SW'(1);
                           end
                        end
                     end
                     OP_POP: begin
                        if (depth_r == DW'(0)) begin
                           underflow_r <= 1'b1;
                        end else begin
                           tos_r   <= nos_r;
                           depth_r <= depth_r - DW'(1);
                           if (depth_r >= DW'(3)) begin
                              sp_r    <= sp_dec_s;
                              state_r <= ST_REFILL;
                           end
                        end
                     end
                     OP_BINOP: begin
                        if (depth_r < DW'(2)) begin
                           underflow_r <= 1'b1;
                        end else begin
                           tos_r   <= core.push_data;
                           depth_r <= depth_r - DW'(1);
                           if (depth_r >= DW'(3)) begin
                              sp_r    <= sp_dec_s;
                              state_r <= ST_REFILL;
                           end
                        end
                     end
                     default: begin
                        state_r <= ST_IDLE;
                     end
                  endcase
               end
            end
            ST_REFILL: begin
               // RAM word addressed in the previous cycle becomes the new NOS.
               nos_r   <= ram_rdata;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/data_stack_unit.md
Name: data_stack_unit

Overview:
Hardware data stack that sits directly downstream of the cpu core's data-stack port and owns the stack pointer and backing RAM traffic.
- The top two entries (TOS, NOS) live in registers so the core reads both operands combinationally every cycle.
- Deeper entries spill to and refill from an external synchronous single-port RAM.
- The core issues one stack op per cycle through a valid/ready handshake.

Parameters:
WIDTH, 16 (STACK_WIDTH), data word width
ADDR_W, 8 (DATA_STACK_SIZE), backing RAM address width; total capacity CAP = 2**ADDR_W + 2

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
op_valid  input  1  op request from core
op  input  2  0=NOP, 1=PUSH, 2=POP, 3=BINOP (pop two, push push_data)
push_data  input  WIDTH  value for PUSH/BINOP
op_ready  output  1  unit accepts op this cycle
tos  output  WIDTH  top of stack
nos  output  WIDTH  next on stack
depth  output  ADDR_W+2  entries held, 0..CAP
overflow  output  1  sticky: PUSH attempted at depth==CAP
underflow  output  1  sticky: POP at depth 0 or BINOP at depth<2
ram_addr  output  ADDR_W  backing RAM address
ram_wdata  output  WIDTH  backing RAM write data
ram_wen  output  1  backing RAM write enable
ram_rdata  input  WIDTH  backing RAM read data, valid one cycle after address

Behaviour:
- Reset (reset==0 at edge): tos=0, nos=0, depth=0, sp=0, overflow=0, underflow=0, state=IDLE, op_ready=1, ram_wen=0. Reset during REFILL abandons the refill.
- Internal sp (ADDR_W+1 bits) = number of entries in RAM = max(depth-2, 0).
- op_ready = (state==IDLE). An op fires when op_valid && op_ready.
- States:
  - IDLE: accepts ops.
  - REFILL: exactly one cycle. nos <= ram_rdata, then return to IDLE. Ops are not accepted.
- PUSH, depth<CAP (1 cycle): nos<=tos, tos<=push_data, depth+1.
  - If depth>=2: same cycle ram_wen=1, ram_addr=sp, ram_wdata=nos (old value), sp+1.
- PUSH, depth==CAP: overflow<=1. No other state changes, no RAM write.
- POP, depth>=1: tos<=nos, depth-1.
  - If depth>=3: same cycle ram_addr=sp-1, sp-1, enter REFILL. Total latency 2 cycles.
  - If depth<=2: 1 cycle. When depth was 2, nos holds its stale value.
- POP, depth==0: underflow<=1, no change.
- BINOP, depth>=2: tos<=push_data, depth-1.
  - If depth>=3: ram_addr=sp-1, sp-1, enter REFILL.
- BINOP, depth<2: underflow<=1, no change.
- NOP, or op_valid low: no state change.
- ram_wen is high only in an accepted spilling PUSH cycle.
- When not reading or writing, ram_addr=sp.
- tos/nos/depth are registered outputs. After a refilling op, nos is updated at the end of the REFILL cycle.
- Sticky flags clear only on reset. An erroring op still completes the handshake (op_ready stays 1).
- No simultaneous RAM read and write can occur: single port, one op at a time.

Decomposition:
- Opcode encodings (OP_NOP/PUSH/POP/BINOP) and the state encoding go in shared consts.vh/opcodes.vh alongside STACK_WIDTH and DATA_STACK_SIZE.
- Sub-module: stack_ram, a synchronous single-port RAM (WIDTH x 2**ADDR_W, registered read, write-first irrelevant). It is instantiated at the top level, not inside this block, so benches can model it.

Test Plan:
All scenarios use ADDR_W=2, CAP=6.
- Reset then PUSH 0x11, 0x22 -> tos=0x22, nos=0x11, depth=2, ram_wen never asserted, op_ready held 1.
- PUSH 0x11..0x66 (six pushes) -> RAM writes addr0=0x11, addr1=0x22, addr2=0x33, addr3=0x44; tos=0x66, nos=0x55, depth=6. A 7th PUSH 0x77 -> overflow=1, depth=6, tos=0x66.
- From that full stack, POP -> tos=0x55, op_ready=0 for exactly one cycle, ram_addr=3, then nos=0x44, depth=5. Repeat POPs down to depth 0 returns 0x44, 0x33, 0x22, 0x11 in order.
- Stack [0x11,0x22,0x33] with tos=0x33; BINOP push_data=0x55 -> tos=0x55, after REFILL nos=0x11, depth=2, sp=0.
- Empty stack: POP -> underflow=1, depth=0. BINOP at depth 1 -> underflow stays 1, tos unchanged.
- Assert reset low during the REFILL cycle -> next cycle all outputs return to reset values, op_ready=1, no late update from ram_rdata.
